memory_request_responder: RTL
=============================

Name: memory_request_responder

Overview:
- Backing-store responder on the memory side of both L1 caches. It serves the instruction cache's refill reads and the data cache's reads and writebacks over the cache-to-memory request/ready handshake.
- One shared single-port word array sits behind a round-robin arbiter. Every access takes a fixed latency, and completion is signalled by a one-cycle ready pulse to the owning port.
- Peripheral decode (address bit 31) happens upstream; this block ignores bit 31.

Parameters:
- DEPTH_LOG2, 10, log2 of the array depth in 32-bit words (1024 words).
- LATENCY, 2, cycles from grant to ready pulse; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- instructionReadEnable  in  1  instruction-side read request, level, held until instructionReady
- instructionAddress  in  32  instruction-side byte address
- instructionDataOut  out  32  read data, valid while instructionReady is high
- instructionReady  out  1  one-cycle completion pulse, instruction side
- dataReadEnable  in  1  data-side read request, level
- dataWriteEnable  in  1  data-side write request, level
- dataAddress  in  32  data-side byte address
- dataIn  in  32  write data
- dataOut  out  32  read data, valid while dataReady is high
- dataReady  out  1  one-cycle completion pulse, data side

Behaviour:
- Reset values: both ready outputs 0, both data outputs 0, state IDLE, last-grant pointer = instruction (so data wins the first tie). Array contents are not cleared.
- Requester contract:
  - Hold enable, address and data stable until ready pulses.
  - An enable still high in the first IDLE cycle after the pulse is a new request.
- States:
  - IDLE: sample both ports.
    - No request: stay in IDLE.
    - One request: grant that port.
    - Both request: grant the port not in the last-grant pointer, then update the pointer.
    - On grant: latch port, address, write flag and write data; load counter with LATENCY-1; go to WAIT.
  - WAIT: decrement the counter. At zero, perform the access at that edge, then go to RESPOND.
    - Read: capture the array word into the granted port's data output.
    - Write: commit to the array. The data output returns the written value.
  - RESPOND: the granted port's ready = 1 for exactly this cycle. The other port's ready stays 0. Next state is always IDLE; enables are ignored during RESPOND.
- Latency:
  - Request first seen high in IDLE cycle t → ready high in cycle t+LATENCY+1.
  - Next grant possible in cycle t+LATENCY+2.
  - Throughput is one access per LATENCY+2 cycles.
- Data-side read and write both high: treated as a write.
- Address mapping:
  - Word index = address[DEPTH_LOG2+1:2]; bits [1:0] ignored (word access only).
  - Out of range means any of bits [30:DEPTH_LOG2+2] nonzero. A read returns 0x00000000, a write is dropped, and ready still pulses with normal latency.
- Output hold: data outputs keep their last value outside the ready cycle. Consumers sample only while ready is high.
- Reset mid-operation (WAIT or RESPOND): abort to IDLE, both readies 0 next cycle, an uncommitted write is dropped, array contents preserved.
- Read-after-write through different ports: the later grant sees the committed value.
- Input changes during WAIT or RESPOND are ignored (requests were latched at grant).

Optional Feature:
- Macro: MEMORY_RESPONDER_STATS_EN.
- Defined: adds outputs instructionGrantCount[15:0], dataGrantCount[15:0] and outOfRangeCount[15:0].
  - Each increments once per grant, wraps at 0xFFFF→0, and resets to 0.
  - outOfRangeCount increments on out-of-range grants of either port.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY=2: reset, data write addr 0x00000010 data 0xDEADBEEF in cycle 0 → dataReady only in cycle 3; instruction read 0x00000010 requested in cycle 4 → instructionReady in cycle 7 with 0xDEADBEEF.
- Both ports request from cycle 0 (data read 0x20, instruction read 0x40), held until their ready → data granted first, ready in cycle 3. Instruction granted at cycle 4, ready in cycle 7. Never both readies in the same cycle.
- Data write 0x00001000 (word 1024, out of range for DEPTH_LOG2=10) data 0x12345678, then read 0x00000000 → write ready pulses and word 0 is unchanged. Read of 0x00001000 returns 0x00000000.
- Write 0x11111111 to addr 0x8, reset asserted in the WAIT cycle → no dataReady. A subsequent read of 0x8 returns the pre-write value.
- dataReadEnable held high continuously on addr 0x4 → ready pulses every LATENCY+2=4 cycles, each one cycle wide.
- With MEMORY_RESPONDER_STATS_EN and LATENCY=1: 3 instruction grants, 2 data grants, 1 out-of-range → counters read 3, 2, 1. Reset clears them to 0.

Source files
------------

// File: rtl/memory_request_responder_if.sv
// Cache-to-memory request/ready bundle shared by the instruction and data L1 refill paths.
// master = cache side (drives requests), slave = memory responder side.
interface memory_request_responder_if;
   logic        instructionReadEnable;
   logic [31:0] instructionAddress;
   logic [31:0] instructionDataOut;
   logic        instructionReady;
   logic        dataReadEnable;
   logic        dataWriteEnable;
   logic [31:0] dataAddress;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        dataReady;

   modport master (
      output instructionReadEnable, instructionAddress,
      output dataReadEnable, dataWriteEnable, dataAddress, dataIn,
      input  instructionDataOut, instructionReady, dataOut, dataReady
   );

   modport slave (
      input  instructionReadEnable, instructionAddress,
      input  dataReadEnable, dataWriteEnable, dataAddress, dataIn,
      output instructionDataOut, instructionReady, dataOut, dataReady
   );
endinterface

// File: rtl/memory_request_responder.sv
// Shared single-port backing store for both L1 caches: round-robin grant, fixed-latency access, one-cycle ready pulse.
// Optional grant/out-of-range counters are built when MEMORY_RESPONDER_STATS_EN is defined.
module memory_request_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic clk,
   input  logic reset,
   memory_request_responder_if.slave bus
`ifdef MEMORY_RESPONDER_STATS_EN
   ,
   output logic [15:0] instructionGrantCount,
   output logic [15:0] dataGrantCount,
   output logic [15:0] outOfRangeCount
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

   state_t                  state_q, state_d;
   logic                    port_q, port_d;      // 1 = data port owns the access
   logic                    last_q, last_d;      // 1 = data port was granted last
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic                    oor_q, oor_d;
   logic                    wr_q, wr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [31:0]             inst_hold_q, inst_hold_d;
   logic [31:0]             data_hold_q, data_hold_d;
   logic [31:0]             rd_word_q;
   logic [31:0]             mem_array [1 << DEPTH_LOG2];

   logic                    data_req, sel_data, access;
   logic [31:0]             sel_addr, resp_word;
   logic                    unused_sel_bits;

`ifdef MEMORY_RESPONDER_STATS_EN
   logic [15:0] igrant_cnt_q, igrant_cnt_d;
   logic [15:0] dgrant_cnt_q, dgrant_cnt_d;
   logic [15:0] oor_cnt_q, oor_cnt_d;
`endif

   assign data_req        = bus.dataReadEnable | bus.dataWriteEnable;
   assign unused_sel_bits = ^{sel_addr[31], sel_addr[1:0]};

   // A dropped out-of-range write still echoes its data; reads from outside the array see zero.
   assign resp_word = wr_q ? wdata_q : (oor_q ? 32'h0 : rd_word_q);

   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      last_d      = last_q;
      idx_d       = idx_q;
      oor_d       = oor_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      inst_hold_d = inst_hold_q;
      data_hold_d = data_hold_q;
      sel_data    = 1'b0;
      sel_addr    = 32'h0;
      access      = 1'b0;
`ifdef MEMORY_RESPONDER_STATS_EN
      igrant_cnt_d = igrant_cnt_q;
      dgrant_cnt_d = dgrant_cnt_q;
      oor_cnt_d    = oor_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.instructionReadEnable || data_req) begin
               if (bus.instructionReadEnable && data_req)
                  sel_data = ~last_q;
               else
                  sel_data = data_req;
               sel_addr = sel_data ? bus.dataAddress : bus.instructionAddress;
               port_d   = sel_data;
               last_d   = sel_data;
               idx_d    = sel_addr[DEPTH_LOG2+1:2];
               oor_d    = |sel_addr[30:DEPTH_LOG2+2];
               wr_d     = sel_data & bus.dataWriteEnable;
               wdata_d  = bus.dataIn;
               cnt_d    = 4'(LATENCY - 1);
               state_d  = S_WAIT;
`ifdef MEMORY_RESPONDER_STATS_EN
               if (sel_data) dgrant_cnt_d = dgrant_cnt_q + 16'd1;
               else          igrant_cnt_d = igrant_cnt_q + 16'd1;
               if (|sel_addr[30:DEPTH_LOG2+2]) oor_cnt_d = oor_cnt_q + 16'd1;
`endif
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = ~reset;
               state_d = S_RESPOND;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESPOND: begin
            if (port_q) data_hold_d = resp_word;
            else        inst_hold_d = resp_word;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         port_q      <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         oor_q       <= 1'b0;
         wr_q        <= 1'b0;
         wdata_q     <= 32'h0;
         cnt_q       <= 4'd0;
         inst_hold_q <= 32'h0;
         data_hold_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         oor_q       <= oor_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         inst_hold_q <= inst_hold_d;
         data_hold_q <= data_hold_d;
      end
   end

   // Array has no reset so contents survive reset and it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (access && wr_q && !oor_q)
         mem_array[idx_q] <= wdata_q;
      if (access && !wr_q)
         rd_word_q <= mem_array[idx_q];
   end

   assign bus.instructionReady   = (state_q == S_RESPOND) && !port_q;
   assign bus.dataReady          = (state_q == S_RESPOND) &&  port_q;
   assign bus.instructionDataOut = bus.instructionReady ? resp_word : inst_hold_q;
   assign bus.dataOut            = bus.dataReady        ? resp_word : data_hold_q;

`ifdef MEMORY_RESPONDER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         igrant_cnt_q <= 16'd0;
         dgrant_cnt_q <= 16'd0;
         oor_cnt_q    <= 16'd0;
      end else begin
         igrant_cnt_q <= igrant_cnt_d;
         dgrant_cnt_q <= dgrant_cnt_d;
         oor_cnt_q    <= oor_cnt_d;
      end
   end

   assign instructionGrantCount = igrant_cnt_q;
   assign dataGrantCount        = dgrant_cnt_q;
   assign outOfRangeCount       = oor_cnt_q;
`endif
endmodule
